// File: rtl/video_timing_generator.sv
// Runtime-reconfigurable raster timing generator with registered outputs.
// New timing arrives on a valid/ready port and takes effect on a frame boundary.
module video_timing_generator #(
  parameter int unsigned p_COUNT_WIDTH = 12,
  parameter int unsigned p_H_ACTIVE    = 640,
  parameter int unsigned p_H_FP        = 16,
  parameter int unsigned p_H_SYNC      = 96,
  parameter int unsigned p_H_BP        = 48,
  parameter int unsigned p_V_ACTIVE    = 480,
  parameter int unsigned p_V_FP        = 10,
  parameter int unsigned p_V_SYNC      = 2,
  parameter int unsigned p_V_BP        = 33,
  parameter bit          p_HSYNC_POL   = 1'b0,
  parameter bit          p_VSYNC_POL   = 1'b0
) (
  input  logic                     i_CLK,
  input  logic                     i_RST_N,
  input  logic                     i_ENABLE,
  input  logic                     i_CFG_VALID,
  output logic                     o_CFG_READY,
  input  logic [p_COUNT_WIDTH-1:0] i_CFG_H_ACTIVE,
  input  logic [p_COUNT_WIDTH-1:0] i_CFG_H_FP,
  input  logic [p_COUNT_WIDTH-1:0] i_CFG_H_SYNC,
  input  logic [p_COUNT_WIDTH-1:0] i_CFG_H_BP,
  input  logic [p_COUNT_WIDTH-1:0] i_CFG_V_ACTIVE,
  input  logic [p_COUNT_WIDTH-1:0] i_CFG_V_FP,
  input  logic [p_COUNT_WIDTH-1:0] i_CFG_V_SYNC,
  input  logic [p_COUNT_WIDTH-1:0] i_CFG_V_BP,
  output logic                     o_CFG_ERR,
  output logic                     o_HSYNC,
  output logic                     o_VSYNC,
  output logic                     o_DE,
  output logic [p_COUNT_WIDTH-1:0] o_X_COORD,
  output logic [p_COUNT_WIDTH-1:0] o_Y_COORD,
  output logic                     o_LINE_START,
  output logic                     o_FRAME_START
);

  typedef logic [p_COUNT_WIDTH-1:0] cnt_t;
  typedef logic [p_COUNT_WIDTH:0]   tot_t;
  typedef logic [p_COUNT_WIDTH+1:0] wide_t;

  typedef struct packed {
    cnt_t h_active;
    cnt_t h_fp;
    cnt_t h_sync;
    cnt_t h_bp;
    cnt_t v_active;
    cnt_t v_fp;
    cnt_t v_sync;
    cnt_t v_bp;
  } timing_t;

  localparam timing_t RstTiming = '{
    h_active: cnt_t'(p_H_ACTIVE),
    h_fp:     cnt_t'(p_H_FP),
    h_sync:   cnt_t'(p_H_SYNC),
    h_bp:     cnt_t'(p_H_BP),
    v_active: cnt_t'(p_V_ACTIVE),
    v_fp:     cnt_t'(p_V_FP),
    v_sync:   cnt_t'(p_V_SYNC),
    v_bp:     cnt_t'(p_V_BP)
  };

  localparam wide_t MaxTotal = wide_t'(1) << p_COUNT_WIDTH;

  timing_t act_q, pend_q, cfg_in;
  logic    pend_valid_q;
  cnt_t    h_q, h_d, v_q, v_d;
  cnt_t    x_q, x_d, y_q, y_d;
  logic    de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic    ls_q, ls_d, fs_q, fs_d, err_q, err_d;

  tot_t    h_total, v_total, hs_start, hs_stop, vs_start, vs_stop;
  wide_t   cfg_h_total, cfg_v_total;
  logic    h_end, v_end, hs_act, vs_act;
  logic    cfg_bad, offer, accept, apply;

  assign cfg_in = '{
    h_active: i_CFG_H_ACTIVE, h_fp: i_CFG_H_FP, h_sync: i_CFG_H_SYNC, h_bp: i_CFG_H_BP,
    v_active: i_CFG_V_ACTIVE, v_fp: i_CFG_V_FP, v_sync: i_CFG_V_SYNC, v_bp: i_CFG_V_BP
  };

  assign hs_start = tot_t'(act_q.h_active) + tot_t'(act_q.h_fp);
  assign hs_stop  = hs_start + tot_t'(act_q.h_sync);
  assign h_total  = hs_stop + tot_t'(act_q.h_bp);
  assign vs_start = tot_t'(act_q.v_active) + tot_t'(act_q.v_fp);
  assign vs_stop  = vs_start + tot_t'(act_q.v_sync);
  assign v_total  = vs_stop + tot_t'(act_q.v_bp);

  assign h_end  = ({1'b0, h_q} == h_total - tot_t'(1));
  assign v_end  = ({1'b0, v_q} == v_total - tot_t'(1));
  assign hs_act = ({1'b0, h_q} >= hs_start) && ({1'b0, h_q} < hs_stop);
  assign vs_act = ({1'b0, v_q} >= vs_start) && ({1'b0, v_q} < vs_stop);

  // Two extra bits so that four maximal fields cannot wrap past the limit check.
  assign cfg_h_total = wide_t'(cfg_in.h_active) + wide_t'(cfg_in.h_fp)
                     + wide_t'(cfg_in.h_sync) + wide_t'(cfg_in.h_bp);
  assign cfg_v_total = wide_t'(cfg_in.v_active) + wide_t'(cfg_in.v_fp)
                     + wide_t'(cfg_in.v_sync) + wide_t'(cfg_in.v_bp);

  assign cfg_bad = (cfg_in.h_active == '0) || (cfg_in.h_sync == '0) ||
                   (cfg_in.v_active == '0) || (cfg_in.v_sync == '0) ||
                   (cfg_h_total > MaxTotal) || (cfg_v_total > MaxTotal);

  assign offer  = i_CFG_VALID && !pend_valid_q;
  assign accept = offer && !cfg_bad;
  assign apply  = pend_valid_q && (!i_ENABLE || (h_end && v_end));
  assign err_d  = offer && cfg_bad;

  always_comb begin
    h_d     = '0;
    v_d     = '0;
    de_d    = 1'b0;
    x_d     = '0;
    y_d     = '0;
    hsync_d = ~p_HSYNC_POL;
    vsync_d = ~p_VSYNC_POL;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    if (i_ENABLE) begin
      h_d = h_end ? '0 : h_q + cnt_t'(1);
      v_d = v_q;
      if (h_end) begin
        v_d = v_end ? '0 : v_q + cnt_t'(1);
      end
      de_d    = (h_q < act_q.h_active) && (v_q < act_q.v_active);
      x_d     = de_d ? h_q : '0;
      y_d     = de_d ? v_q : '0;
      hsync_d = hs_act ? p_HSYNC_POL : ~p_HSYNC_POL;
      vsync_d = vs_act ? p_VSYNC_POL : ~p_VSYNC_POL;
      ls_d    = (h_q == '0);
      fs_d    = (h_q == '0) && (v_q == '0);
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      act_q        <= RstTiming;
      pend_q       <= RstTiming;
      pend_valid_q <= 1'b0;
      h_q          <= '0;
      v_q          <= '0;
      de_q         <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      hsync_q      <= ~p_HSYNC_POL;
      vsync_q      <= ~p_VSYNC_POL;
      ls_q         <= 1'b0;
      fs_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // Capture and apply are exclusive: a full slot holds READY low.
      if (accept) begin
        pend_q       <= cfg_in;
        pend_valid_q <= 1'b1;
      end else if (apply) begin
        act_q        <= pend_q;
        pend_valid_q <= 1'b0;
      end
      h_q     <= h_d;
      v_q     <= v_d;
      de_q    <= de_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      err_q   <= err_d;
    end
  end

  assign o_CFG_READY   = ~pend_valid_q;
  assign o_CFG_ERR     = err_q;
  assign o_HSYNC       = hsync_q;
  assign o_VSYNC       = vsync_q;
  assign o_DE          = de_q;
  assign o_X_COORD     = x_q;
  assign o_Y_COORD     = y_q;
  assign o_LINE_START  = ls_q;
  assign o_FRAME_START = fs_q;

endmodule

// File: tb/tb_video_timing_generator.sv
// Directed bench: default 640x480 timing, config reload/reject, enable and reset,
// with a second instance using active-high sync polarity.
module tb_video_timing_generator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [11:0] c_ha = 12'd0, c_hfp = 12'd0, c_hs = 12'd0, c_hbp = 12'd0;
  logic [11:0] c_va = 12'd0, c_vfp = 12'd0, c_vs = 12'd0, c_vbp = 12'd0;

  logic        ready, err, hsync, vsync, de, ls, fs;
  logic [11:0] x, y;
  logic        p_ready, p_err, p_hsync, p_vsync, p_de, p_ls, p_fs;
  logic [11:0] p_x, p_y;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int n_de, n_hs, n_vs, n_ls, n_fs, n_phs, n_pvs, max_x, max_y;

  video_timing_generator dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_ENABLE(enable), .i_CFG_VALID(cfg_valid),
    .o_CFG_READY(ready),
    .i_CFG_H_ACTIVE(c_ha), .i_CFG_H_FP(c_hfp), .i_CFG_H_SYNC(c_hs), .i_CFG_H_BP(c_hbp),
    .i_CFG_V_ACTIVE(c_va), .i_CFG_V_FP(c_vfp), .i_CFG_V_SYNC(c_vs), .i_CFG_V_BP(c_vbp),
    .o_CFG_ERR(err), .o_HSYNC(hsync), .o_VSYNC(vsync), .o_DE(de),
    .o_X_COORD(x), .o_Y_COORD(y), .o_LINE_START(ls), .o_FRAME_START(fs)
  );

  video_timing_generator #(.p_HSYNC_POL(1'b1), .p_VSYNC_POL(1'b1)) dut_pol (
    .i_CLK(clk), .i_RST_N(rst_n), .i_ENABLE(enable), .i_CFG_VALID(cfg_valid),
    .o_CFG_READY(p_ready),
    .i_CFG_H_ACTIVE(c_ha), .i_CFG_H_FP(c_hfp), .i_CFG_H_SYNC(c_hs), .i_CFG_H_BP(c_hbp),
    .i_CFG_V_ACTIVE(c_va), .i_CFG_V_FP(c_vfp), .i_CFG_V_SYNC(c_vs), .i_CFG_V_BP(c_vbp),
    .o_CFG_ERR(p_err), .o_HSYNC(p_hsync), .o_VSYNC(p_vsync), .o_DE(p_de),
    .o_X_COORD(p_x), .o_Y_COORD(p_y), .o_LINE_START(p_ls), .o_FRAME_START(p_fs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  // Steps n cycles, tallying active cycles of each output (default DUT syncs are active-low).
  task automatic run_count(input int n);
    n_de = 0; n_hs = 0; n_vs = 0; n_ls = 0; n_fs = 0; n_phs = 0; n_pvs = 0;
    max_x = 0; max_y = 0;
    repeat (n) begin
      step(1);
      n_de  += int'(de);
      n_hs  += int'(!hsync);
      n_vs  += int'(!vsync);
      n_ls  += int'(ls);
      n_fs  += int'(fs);
      n_phs += int'(p_hsync);
      n_pvs += int'(p_vsync);
      if (int'(x) > max_x) max_x = int'(x);
      if (int'(y) > max_y) max_y = int'(y);
    end
  endtask

  task automatic offer(input int ha, input int hfp, input int hs, input int hbp,
                       input int va, input int vfp, input int vs, input int vbp);
    c_ha = 12'(ha); c_hfp = 12'(hfp); c_hs = 12'(hs); c_hbp = 12'(hbp);
    c_va = 12'(va); c_vfp = 12'(vfp); c_vs = 12'(vs); c_vbp = 12'(vbp);
    cfg_valid = 1'b1;
  endtask

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", ready, 1);
    chk("rst_err", err, 0);
    chk("rst_de", de, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_xy", {x, y}, 0);
    chk("rst_strobes", {ls, fs}, 0);
    chk("rst_pol_syncs", {p_hsync, p_vsync}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Default 800x525 timing, first line
    enable = 1'b1;
    k = 0;
    run_count(800);
    chk("l0_de_cnt", n_de, 640);
    chk("l0_hs_cnt", n_hs, 96);
    chk("l0_pol_hs_cnt", n_phs, 96);
    chk("l0_vs_cnt", n_vs + n_pvs, 0);
    chk("l0_ls_cnt", n_ls, 1);
    chk("l0_fs_cnt", n_fs, 1);
    chk("l0_max_x", max_x, 639);
    chk("l0_max_y", max_y, 0);
    step(1);
    chk("l1_start", {ls, fs, de}, 3'b101);
    chk("l1_xy", {x, y}, {12'd0, 12'd1});

    // Rejected configs leave READY high and timing unchanged
    offer(640, 16, 0, 48, 480, 10, 2, 33);
    step(1);
    cfg_valid = 1'b0;
    chk("rej1_err", err, 1);
    chk("rej1_ready", ready, 1);
    step(1);
    chk("rej1_err_clr", err, 0);
    offer(640, 16, 96, 48, 4095, 10, 2, 2);
    step(1);
    cfg_valid = 1'b0;
    chk("rej2_err", err, 1);
    chk("rej2_ready", ready, 1);
    step(1);
    chk("rej2_err_clr", err, 0);
    step(1456 - k);
    chk("l1_pre_hs", {hsync, p_hsync}, 2'b10);
    step(1);
    chk("l1_hs_edge", {hsync, p_hsync}, 2'b01);
    step(1601 - k);
    chk("l2_start", {ls, de}, 2'b11);
    chk("l2_xy", {x, y}, {12'd0, 12'd2});

    // Disable at h=300, v=10 and re-enable
    step(8300 - k);
    chk("pre_dis_de", de, 1);
    chk("pre_dis_xy", {x, y}, {12'd299, 12'd10});
    enable = 1'b0;
    step(1);
    chk("dis_de", de, 0);
    chk("dis_xy", {x, y}, 0);
    chk("dis_syncs", {hsync, vsync, p_hsync, p_vsync}, 4'b1100);
    step(1);
    enable = 1'b1;
    step(1);
    chk("reen_strobes", {fs, ls, de}, 3'b111);
    chk("reen_xy", {x, y}, 0);

    // Loads while disabled apply on the following edge; total of exactly 4096 is legal
    enable = 1'b0;
    step(1);
    offer(8, 0, 3, 5, 4090, 2, 2, 2);
    step(1);
    cfg_valid = 1'b0;
    chk("max_err", err, 0);
    chk("max_ready_lo", ready, 0);
    step(1);
    chk("max_ready_hi", ready, 1);
    offer(8, 0, 3, 5, 4, 1, 2, 1);
    step(1);
    cfg_valid = 1'b0;
    chk("a_ready_lo", ready, 0);
    step(1);
    chk("a_ready_hi", ready, 1);

    // 16x8 frame
    enable = 1'b1;
    k = 0;
    run_count(128);
    chk("a_de_cnt", n_de, 32);
    chk("a_hs_cnt", n_hs, 24);
    chk("a_vs_cnt", n_vs, 32);
    chk("a_pol_cnt", {n_phs[15:0], n_pvs[15:0]}, {16'd24, 16'd32});
    chk("a_ls_cnt", n_ls, 8);
    chk("a_fs_cnt", n_fs, 1);
    chk("a_max_xy", {max_x[15:0], max_y[15:0]}, {16'd7, 16'd3});
    step(1);
    chk("a_fs_period", fs, 1);

    // Mid-frame offer applies at the end of the 16x8 frame
    step(10);
    offer(4, 1, 2, 1, 2, 1, 1, 1);
    step(1);
    cfg_valid = 1'b0;
    chk("b_err", err, 0);
    chk("b_ready_lo", ready, 0);
    step(255 - k);
    chk("b_ready_hold", ready, 0);
    step(1);
    chk("b_ready_hi", ready, 1);
    chk("b_old_fs", fs, 0);
    run_count(40);
    chk("b_de_cnt", n_de, 8);
    chk("b_hs_cnt", n_hs, 10);
    chk("b_vs_cnt", n_vs, 8);
    chk("b_ls_fs", {n_ls[15:0], n_fs[15:0]}, {16'd5, 16'd1});
    chk("b_max_xy", {max_x[15:0], max_y[15:0]}, {16'd3, 16'd1});
    step(1);
    chk("b_fs_period", fs, 1);

    // Asynchronous reset with a config pending
    offer(8, 0, 3, 5, 4, 1, 2, 1);
    step(1);
    cfg_valid = 1'b0;
    chk("c_ready_lo", ready, 0);
    chk("c_pre_rst", {de, x}, {1'b1, 12'd1});
    #2 rst_n = 1'b0;
    #1;
    chk("arst_de_xy", {de, x, y}, 0);
    chk("arst_syncs", {hsync, vsync, p_hsync, p_vsync}, 4'b1100);
    chk("arst_ready", ready, 1);
    #1 rst_n = 1'b1;
    k = 0;
    run_count(800);
    chk("post_de_cnt", n_de, 640);
    chk("post_hs_cnt", n_hs, 96);
    chk("post_fs_cnt", n_fs, 1);
    chk("post_ready", ready, 1);
    step(1);
    chk("post_l1", {ls, y}, {1'b1, 12'd1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
